// File: rtl/game_pkg.sv
// Shared game definitions: scheduler FSM states, screen geometry and the
// 10-bit coordinate type used by every sprite block.
package game_pkg;

   typedef logic [9:0] coord_t;

   localparam int SCREEN_TOP_Y    = 31;
   localparam int SCREEN_BOTTOM_Y = 511;
   localparam int SCREEN_X_MIN    = 144;
   localparam int SCREEN_X_MAX    = 783;

   localparam int COOL_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_PAUSED = 2'd2
   } sched_state_e;

   typedef struct packed {
      sched_state_e        state;
      logic                pending;
      logic [COOL_W-1:0]   cooldown;
   } sched_dbg_t;

endpackage

// File: rtl/prio_enc.sv
// Lowest-index-first priority encoder with a valid flag; used to pick a free
// bullet slot.
module prio_enc #(
   parameter int N = 5,
   parameter int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0] i_req,
   output logic [W-1:0] o_idx,
   output logic         o_valid
);

   // Scanning downward lets the lowest requesting index win the last write.
   always_comb begin
      o_idx   = '0;
      o_valid = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (i_req[i]) begin
            o_idx   = W'(i);
            o_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bullet_sched.sv
// Bullet slot scheduler: allocates, moves and retires player bullets on each
// motion tick. Define BULLET_AUTOFIRE_EN for hold-to-fire behaviour.
module bullet_sched
   import game_pkg::*;
#(
   parameter int NSLOTS   = 5,
   parameter int COOLDOWN = 8,
   parameter int SPEED    = 4,
   parameter int TOP_Y    = SCREEN_TOP_Y,
   parameter int SPAWN_Y  = 440
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  tick,
   input  logic                  game_active,
   input  logic                  pause,
   input  logic                  fire,
   input  logic [9:0]            p_x,
   input  logic [NSLOTS-1:0]     b_hit,
   output logic [NSLOTS-1:0]     b_active,
   output logic [10*NSLOTS-1:0]  b_x,
   output logic [10*NSLOTS-1:0]  b_y,
   output logic                  spawn,
   output logic [7:0]            drop_cnt,
   output sched_dbg_t            dbg
);

   localparam int     IDX_W      = (NSLOTS > 1) ? $clog2(NSLOTS) : 1;
   localparam coord_t RETIRE_LIM = coord_t'(TOP_Y + SPEED);

   sched_state_e      r_state, w_state_nxt;
   logic              w_run;

   logic [NSLOTS-1:0] r_active, w_active_nxt;
   coord_t            r_x     [NSLOTS];
   coord_t            r_y     [NSLOTS];
   coord_t            w_x_nxt [NSLOTS];
   coord_t            w_y_nxt [NSLOTS];
   logic              r_pending, w_pending_nxt;
   logic [COOL_W-1:0] r_cooldown, w_cool_nxt;
   logic              r_spawn, w_spawn_nxt;
   logic [7:0]        r_drop, w_drop_nxt;
   logic              r_fire_q;

   logic              w_fire_rise, w_fire_set, w_req;
   logic [NSLOTS-1:0] w_free_req;
   logic [IDX_W-1:0]  w_free_idx;
   logic              w_free_vld;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= ST_IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_run       = 1'b0;
      case (r_state)
         ST_IDLE:   if (game_active) w_state_nxt = ST_RUN;
         ST_RUN: begin
            w_run = 1'b1;
            if (pause) w_state_nxt = ST_PAUSED;
         end
         ST_PAUSED: if (!pause) w_state_nxt = ST_RUN;
         default:   w_state_nxt = ST_IDLE;
      endcase
      if (!game_active) w_state_nxt = ST_IDLE;
   end

   assign w_fire_rise = fire & ~r_fire_q;
`ifdef BULLET_AUTOFIRE_EN
   assign w_fire_set  = w_fire_rise | (fire & (r_cooldown == '0));
`else
   assign w_fire_set  = w_fire_rise;
`endif
   // A fire edge in the tick cycle itself counts toward that tick's spawn.
   assign w_req       = r_pending | (w_run & w_fire_set);
   assign w_free_req  = ~r_active;

   prio_enc #(
      .N (NSLOTS),
      .W (IDX_W)
   ) u_free_slot (
      .i_req   (w_free_req),
      .o_idx   (w_free_idx),
      .o_valid (w_free_vld)
   );

   always_comb begin
      w_active_nxt  = r_active;
      w_x_nxt       = r_x;
      w_y_nxt       = r_y;
      w_pending_nxt = r_pending;
      w_cool_nxt    = r_cooldown;
      w_spawn_nxt   = 1'b0;
      w_drop_nxt    = r_drop;
      if (!game_active) begin
         w_active_nxt  = '0;
         w_pending_nxt = 1'b0;
         w_cool_nxt    = '0;
      end else if (w_run) begin
         w_active_nxt  = r_active & ~b_hit;
         w_pending_nxt = w_req;
         if (tick) begin
            for (int i = 0; i < NSLOTS; i++) begin
               if (r_active[i] && !b_hit[i]) begin
                  if (r_y[i] < RETIRE_LIM) w_active_nxt[i] = 1'b0;
                  else                     w_y_nxt[i] = r_y[i] - coord_t'(SPEED);
               end
            end
            if (r_cooldown != '0) w_cool_nxt = r_cooldown - COOL_W'(1);
            if (w_req && (r_cooldown == '0)) begin
               w_pending_nxt = 1'b0;
               if (w_free_vld) begin
                  w_spawn_nxt = 1'b1;
                  w_cool_nxt  = COOL_W'(COOLDOWN);
               end else if (r_drop != 8'hFF) begin
                  w_drop_nxt = r_drop + 8'd1;
               end
            end
            // The chosen slot was free before this tick, so no retire or hit competes with it.
            for (int i = 0; i < NSLOTS; i++) begin
               if (w_spawn_nxt && (i == int'(w_free_idx))) begin
                  w_active_nxt[i] = 1'b1;
                  w_x_nxt[i]      = p_x;
                  w_y_nxt[i]      = coord_t'(SPAWN_Y);
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_active   <= '0;
         r_x        <= '{default: '0};
         r_y        <= '{default: '0};
         r_pending  <= 1'b0;
         r_cooldown <= '0;
         r_spawn    <= 1'b0;
         r_drop     <= '0;
         r_fire_q   <= 1'b0;
      end else begin
         r_active   <= w_active_nxt;
         r_x        <= w_x_nxt;
         r_y        <= w_y_nxt;
         r_pending  <= w_pending_nxt;
         r_cooldown <= w_cool_nxt;
         r_spawn    <= w_spawn_nxt;
         r_drop     <= w_drop_nxt;
         r_fire_q   <= fire;
      end
   end

   for (genvar g = 0; g < NSLOTS; g++) begin : g_pack
      assign b_x[10*g +: 10] = r_x[g];
      assign b_y[10*g +: 10] = r_y[g];
   end

   assign b_active = r_active;
   assign spawn    = r_spawn;
   assign drop_cnt = r_drop;
   assign dbg      = '{state: r_state, pending: r_pending, cooldown: r_cooldown};

endmodule

// File: tb/tb_bullet_sched.sv
// Bench for bullet_sched: directed scenarios and randomized traffic, every
// cycle compared against a slot-level behavioural model.
module tb_bullet_sched;
   import game_pkg::*;

   localparam int NS   = 5;
   localparam int COOL = 8;
   localparam int SPD  = 4;
   localparam int TOPY = 31;
   localparam int SPY  = 440;

   localparam int M_IDLE   = 0;
   localparam int M_RUN    = 1;
   localparam int M_PAUSED = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             tick = 1'b0;
   logic             game_active = 1'b0;
   logic             pause = 1'b0;
   logic             fire = 1'b0;
   logic [9:0]       p_x = '0;
   logic [NS-1:0]    b_hit = '0;
   logic [NS-1:0]    b_active;
   logic [10*NS-1:0] b_x;
   logic [10*NS-1:0] b_y;
   logic             spawn;
   logic [7:0]       drop_cnt;
   sched_dbg_t       dbg;

   int n_checks = 0;
   int n_errors = 0;

   // model state
   int          m_x [NS];
   int          m_y [NS];
   bit          m_act [NS];
   bit          m_pend, m_spawn, m_fire_q, m_rise;
   int          m_cool, m_drop, m_mode;
   logic [13:0] exp_q[$];
   logic [NS-1:0] prev_act = '0;

   bullet_sched #(
      .NSLOTS   (NS),
      .COOLDOWN (COOL),
      .SPEED    (SPD),
      .TOP_Y    (TOPY),
      .SPAWN_Y  (SPY)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .tick        (tick),
      .game_active (game_active),
      .pause       (pause),
      .fire        (fire),
      .p_x         (p_x),
      .b_hit       (b_hit),
      .b_active    (b_active),
      .b_x         (b_x),
      .b_y         (b_y),
      .spawn       (spawn),
      .drop_cnt    (drop_cnt),
      .dbg         (dbg)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NS; i++) begin
         m_x[i] = 0; m_y[i] = 0; m_act[i] = 1'b0;
      end
      m_pend = 0; m_spawn = 0; m_fire_q = 0;
      m_cool = 0; m_drop = 0; m_mode = M_IDLE;
      exp_q.delete();
   endtask

   task automatic model_run(input bit rise);
      bit req, set;
      int free_slot, old_cool;
      set = rise;
`ifdef BULLET_AUTOFIRE_EN
      set = set || (fire && m_cool == 0);
`endif
      req = m_pend || set;
      free_slot = -1;
      for (int i = 0; i < NS; i++)
         if (!m_act[i] && free_slot < 0) free_slot = i;
      for (int i = 0; i < NS; i++) begin
         if (m_act[i]) begin
            if (b_hit[i]) m_act[i] = 1'b0;
            else if (tick) begin
               if (m_y[i] < TOPY + SPD) m_act[i] = 1'b0;
               else                     m_y[i] -= SPD;
            end
         end
      end
      m_pend = req;
      if (tick) begin
         old_cool = m_cool;
         if (m_cool > 0) m_cool--;
         if (req && old_cool == 0) begin
            m_pend = 0;
            if (free_slot >= 0) begin
               m_act[free_slot] = 1'b1;
               m_x[free_slot]   = int'(p_x);
               m_y[free_slot]   = SPY;
               m_spawn          = 1'b1;
               m_cool           = COOL;
               exp_q.push_back({4'(free_slot), p_x});
            end else if (m_drop < 255) begin
               m_drop++;
            end
         end
      end
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) model_reset();
      else begin
         m_rise   = fire && !m_fire_q;
         m_fire_q = fire;
         m_spawn  = 1'b0;
         if (!game_active) begin
            for (int i = 0; i < NS; i++) m_act[i] = 1'b0;
            m_pend = 0; m_cool = 0; m_mode = M_IDLE;
         end else if (m_mode == M_IDLE) begin
            m_mode = M_RUN;
         end else if (m_mode == M_PAUSED) begin
            if (!pause) m_mode = M_RUN;
         end else begin
            model_run(m_rise);
            if (pause) m_mode = M_PAUSED;
         end
      end
   end

   function automatic logic [NS-1:0] pack_act();
      logic [NS-1:0] v;
      for (int i = 0; i < NS; i++) v[i] = m_act[i];
      return v;
   endfunction

   function automatic logic [10*NS-1:0] pack_x();
      logic [10*NS-1:0] v;
      for (int i = 0; i < NS; i++) v[10*i +: 10] = 10'(m_x[i]);
      return v;
   endfunction

   function automatic logic [10*NS-1:0] pack_y();
      logic [10*NS-1:0] v;
      for (int i = 0; i < NS; i++) v[10*i +: 10] = 10'(m_y[i]);
      return v;
   endfunction

   function automatic sched_state_e exp_state();
      case (m_mode)
         M_RUN:    return ST_RUN;
         M_PAUSED: return ST_PAUSED;
         default:  return ST_IDLE;
      endcase
   endfunction

   function automatic logic [9:0] dut_x(input int s);
      return b_x[10*s +: 10];
   endfunction

   function automatic logic [9:0] dut_y(input int s);
      return b_y[10*s +: 10];
   endfunction

   task automatic compare_all();
      logic [NS-1:0] newly;
      logic [13:0]   got, exp;
      int            slot;
      check_val("b_active", 64'(b_active), 64'(pack_act()));
      check_val("b_x", 64'(b_x), 64'(pack_x()));
      check_val("b_y", 64'(b_y), 64'(pack_y()));
      check_val("spawn", 64'(spawn), 64'(m_spawn));
      check_val("drop_cnt", 64'(drop_cnt), 64'(m_drop));
      check_val("state", 64'(dbg.state), 64'(exp_state()));
      check_val("pending", 64'(dbg.pending), 64'(m_pend));
      check_val("cooldown", 64'(dbg.cooldown), 64'(m_cool));
      if (spawn) begin
         newly = b_active & ~prev_act;
         slot  = 15;
         for (int i = NS - 1; i >= 0; i--) if (newly[i]) slot = i;
         check_val("sb_pending", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            got = {4'(slot), 10'd0};
            if (slot < NS) got[9:0] = dut_x(slot);
            check_val("sb_spawn", 64'(got), 64'(exp));
         end
      end
      prev_act = b_active;
   endtask

   task automatic step(input logic t);
      tick = t;
      @(posedge clk);
      @(negedge clk);
      compare_all();
      tick  = 1'b0;
      b_hit = '0;
   endtask

   task automatic tick_n(input int n);
      repeat (n) begin
         step(1'b1);
         step(1'b0);
      end
   endtask

   task automatic fire_pulse();
      fire = 1'b1;
      step(1'b0);
      fire = 1'b0;
      step(1'b0);
   endtask

   initial begin
      int exp_y2;
      logic [10*NS-1:0] snap_y;

      repeat (3) step(1'b0);
      check_val("rst_active", 64'(b_active), 64'd0);
      check_val("rst_x", 64'(b_x), 64'd0);
      check_val("rst_y", 64'(b_y), 64'd0);
      check_val("rst_spawn", 64'(spawn), 64'd0);
      check_val("rst_drop", 64'(drop_cnt), 64'd0);
      check_val("rst_state", 64'(dbg.state), 64'(ST_IDLE));

      // first shot
      rst = 1'b1;
      game_active = 1'b1;
      p_x = 10'd400;
      step(1'b0);
      step(1'b0);
      check_val("run_state", 64'(dbg.state), 64'(ST_RUN));
      fire_pulse();
      step(1'b1);
      check_val("d1_spawn", 64'(spawn), 64'd1);
      check_val("d1_active", 64'(b_active), 64'h01);
      check_val("d1_x", 64'(dut_x(0)), 64'd400);
      check_val("d1_y", 64'(dut_y(0)), 64'd440);

      // full flight to retirement
      tick_n(101);
      check_val("fly_y101", 64'(dut_y(0)), 64'd36);
      check_val("fly_act101", 64'(b_active[0]), 64'd1);
      tick_n(1);
      check_val("fly_y102", 64'(dut_y(0)), 64'd32);
      check_val("fly_act102", 64'(b_active[0]), 64'd1);
      tick_n(1);
      check_val("fly_retire", 64'(b_active[0]), 64'd0);
      check_val("fly_y_hold", 64'(dut_y(0)), 64'd32);

      // fill every slot, then one refused request
      for (int k = 0; k < 5; k++) begin
         p_x = 10'(200 + 50 * k);
         fire_pulse();
         tick_n(10);
      end
      check_val("fill_active", 64'(b_active), 64'h1f);
      check_val("fill_drop", 64'(drop_cnt), 64'd0);
      fire_pulse();
      tick_n(10);
      check_val("drop1", 64'(drop_cnt), 64'd1);
      check_val("drop1_active", 64'(b_active), 64'h1f);

      // hit coinciding with a tick, then reuse of the lowest free slot
      exp_y2 = m_y[2];
      b_hit = 5'b00100;
      step(1'b1);
      check_val("hit_act", 64'(b_active), 64'h1b);
      check_val("hit_y2", 64'(dut_y(2)), 64'(exp_y2));
      b_hit = 5'b01000;
      step(1'b0);
      check_val("hit3_act", 64'(b_active), 64'h13);
      p_x = 10'd700;
      fire_pulse();
      step(1'b1);
      check_val("realloc_act", 64'(b_active), 64'h17);
      check_val("realloc_x", 64'(dut_x(2)), 64'd700);
      check_val("realloc_y", 64'(dut_y(2)), 64'd440);

      // pause freezes motion and cooldown
      tick_n(2);
      check_val("pre_cool", 64'(dbg.cooldown), 64'd6);
      snap_y = pack_y();
      pause = 1'b1;
      step(1'b0);
      check_val("pause_state", 64'(dbg.state), 64'(ST_PAUSED));
      for (int k = 0; k < 50; k++) begin
         if (k % 10 == 0) fire_pulse();
         step(1'b1);
         step(1'b0);
      end
      check_val("pause_y", 64'(b_y), 64'(snap_y));
      check_val("pause_cool", 64'(dbg.cooldown), 64'd6);
      check_val("pause_pend", 64'(dbg.pending), 64'd0);
      pause = 1'b0;
      step(1'b0);
      step(1'b1);
      check_val("resume_y2", 64'(dut_y(2)), 64'd428);
      check_val("resume_cool", 64'(dbg.cooldown), 64'd5);

      // leaving play discards bullets but keeps the drop count
      game_active = 1'b0;
      step(1'b0);
      check_val("idle_act", 64'(b_active), 64'd0);
      check_val("idle_drop", 64'(drop_cnt), 64'd1);
      check_val("idle_state", 64'(dbg.state), 64'(ST_IDLE));
      check_val("idle_cool", 64'(dbg.cooldown), 64'd0);
      game_active = 1'b1;
      step(1'b0);

      // randomized traffic
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 3) == 0) fire = ~fire;
         if ($urandom_range(0, 39) == 0) pause = ~pause;
         game_active = ($urandom_range(0, 299) != 0);
         p_x = 10'($urandom_range(144, 783));
         if ($urandom_range(0, 7) == 0) b_hit = NS'(1 << $urandom_range(0, NS - 1));
         step($urandom_range(0, 2) == 0);
      end

      // drop counter saturation
      game_active = 1'b1;
      pause = 1'b0;
      fire = 1'b0;
      step(1'b0);
      step(1'b0);
      repeat (600) begin
         fire_pulse();
         step(1'b1);
      end
      check_val("sat_drop", 64'(drop_cnt), 64'd255);
      check_val("sb_drain", 64'(exp_q.size()), 64'd0);

      // asynchronous reset mid-flight
      repeat (12) begin
         fire_pulse();
         step(1'b1);
      end
      #2 rst = 1'b0;
      #1;
      check_val("ar_active", 64'(b_active), 64'd0);
      check_val("ar_y", 64'(b_y), 64'd0);
      check_val("ar_spawn", 64'(spawn), 64'd0);
      check_val("ar_state", 64'(dbg.state), 64'(ST_IDLE));
      step(1'b0);
      rst = 1'b1;
      step(1'b0);
      step(1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
